// File: rtl/division_pkg.sv
// division_pkg: shared width, FSM states and divide-by-zero answer for the division arbiter
package division_pkg;
  localparam int SIZE = 128;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;
  localparam logic [SIZE-1:0] DIV_ZERO_RESULT = '1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick with a pointer that moves past the requester just served
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       gnt,
  output logic       gnt_valid
);
  logic ptr_q, ptr_d;
  assign gnt_valid = |req;
  assign gnt = &req ? ptr_q : req[1];
  // favour the other requester once the current one has consumed its result
  always_comb ptr_d = advance ? !served : ptr_q;
  // pointer register, starts out favouring req0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end
endmodule

// File: rtl/division_arbiter.sv
// division_arbiter: shares one divider core between two requesters, one transaction at a time
module division_arbiter #(
  parameter int SIZE = division_pkg::SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   req0_dividend_tdata,
  input  logic [SIZE/2-1:0] req0_divisor_tdata,
  input  logic              req0_tvalid,
  output logic              req0_tready,
  input  logic [SIZE-1:0]   req1_dividend_tdata,
  input  logic [SIZE/2-1:0] req1_divisor_tdata,
  input  logic              req1_tvalid,
  output logic              req1_tready,
  output logic [SIZE-1:0]   res0_tdata,
  output logic              res0_tvalid,
  input  logic              res0_tready,
  output logic [SIZE-1:0]   res1_tdata,
  output logic              res1_tvalid,
  input  logic              res1_tready,
  output logic [SIZE-1:0]   div_dividend_tdata,
  output logic              div_dividend_tvalid,
  input  logic              div_dividend_tready,
  output logic [SIZE/2-1:0] div_divisor_tdata,
  output logic              div_divisor_tvalid,
  input  logic              div_divisor_tready,
  input  logic [SIZE-1:0]   div_output_tdata,
  input  logic              div_output_tvalid,
  output logic              div_output_tready,
  output logic              busy,
  output logic              grant
);
  import division_pkg::*;
  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [SIZE-1:0]   dd_q, dd_d;
  logic [SIZE/2-1:0] ds_q, ds_d;
  logic [SIZE-1:0]   res_q, res_d;
  logic              dd_done_q, dd_done_d;
  logic              ds_done_q, ds_done_d;
  logic              win, win_valid, res_tready_g, advance;
  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1_tvalid, req0_tvalid}),
    .advance   (advance),
    .served    (grant_q),
    .gnt       (win),
    .gnt_valid (win_valid)
  );
  assign res_tready_g        = grant_q ? res1_tready : res0_tready;
  assign advance             = state_q == RESP && res_tready_g;
  assign busy                = state_q != IDLE;
  assign grant               = grant_q;
  assign req0_tready         = rst && state_q == IDLE && win_valid && !win;
  assign req1_tready         = rst && state_q == IDLE && win_valid && win;
  assign res0_tvalid         = state_q == RESP && !grant_q;
  assign res1_tvalid         = state_q == RESP && grant_q;
  assign res0_tdata          = res_q;
  assign res1_tdata          = res_q;
  assign div_dividend_tdata  = dd_q;
  assign div_divisor_tdata   = ds_q;
  assign div_dividend_tvalid = state_q == LOAD && !dd_done_q;
  assign div_divisor_tvalid  = state_q == LOAD && !ds_done_q;
  assign div_output_tready   = state_q == WAIT;
  // next-state, operand capture, handshake flags and result capture
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    dd_d      = dd_q;
    ds_d      = ds_q;
    res_d     = res_q;
    dd_done_d = dd_done_q;
    ds_done_d = ds_done_q;
    case (state_q)
      IDLE: if (win_valid) begin
        grant_d   = win;
        dd_d      = win ? req1_dividend_tdata : req0_dividend_tdata;
        ds_d      = win ? req1_divisor_tdata : req0_divisor_tdata;
        dd_done_d = 1'b0;
        ds_done_d = 1'b0;
        state_d   = ds_d == '0 ? RESP : LOAD;
        res_d     = ds_d == '0 ? {SIZE{DIV_ZERO_RESULT[0]}} : res_q;
      end
      LOAD: begin
        dd_done_d = dd_done_q | div_dividend_tready;
        ds_done_d = ds_done_q | div_divisor_tready;
        state_d   = dd_done_d && ds_done_d ? WAIT : LOAD;
      end
      WAIT: if (div_output_tvalid) begin
        res_d   = div_output_tdata;
        state_d = RESP;
      end
      RESP: state_d = res_tready_g ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      dd_q      <= '0;
      ds_q      <= '0;
      res_q     <= '0;
      dd_done_q <= 1'b0;
      ds_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      dd_q      <= dd_d;
      ds_q      <= ds_d;
      res_q     <= res_d;
      dd_done_q <= dd_done_d;
      ds_done_q <= ds_done_d;
    end
  end
endmodule

// File: doc/division_arbiter.md
# division_arbiter

Shares one `division` core (SIZE-bit dividend, SIZE/2-bit divisor, valid/ready streams) between two requesters in the ElGamal datapath, for example the modular-exponentiation engine and the key/ciphertext reduction path. Requests are granted round-robin and the grant is held until the requester consumes its result. Each granted request's operands are registered and sequenced through the divider's two input handshakes and its output handshake. The result is routed back to the granted requester; a zero divisor is answered locally without using the divider.

## Interface
Parameters:
- `SIZE`, 128: dividend and result width; divisor width is SIZE/2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `reqN_dividend_tdata` in SIZE: requester N dividend, N in {0,1}.
- `reqN_divisor_tdata` in SIZE/2: requester N divisor.
- `reqN_tvalid` in 1: requester N holds a valid operand pair.
- `reqN_tready` out 1: operand pair accepted when high together with `reqN_tvalid`.
- `resN_tdata` out SIZE: result returned to requester N.
- `resN_tvalid` out 1: result for requester N is valid.
- `resN_tready` in 1: requester N consumes its result.
- `div_dividend_tdata` out SIZE, `div_dividend_tvalid` out 1, `div_dividend_tready` in 1: divider dividend stream.
- `div_divisor_tdata` out SIZE/2, `div_divisor_tvalid` out 1, `div_divisor_tready` in 1: divider divisor stream.
- `div_output_tdata` in SIZE, `div_output_tvalid` in 1, `div_output_tready` out 1: divider result stream.
- `busy` out 1: high in any state other than IDLE.
- `grant` out 1: index of the requester currently being served.

## Operation
- **State machine:** IDLE, LOAD, WAIT, RESP.
- **IDLE:**
  - Winner selection: if only one `reqN_tvalid` is high, that requester wins. If both are high, the winner is the requester not served last. The priority pointer resets to favour req0.
  - `reqN_tready` is high combinationally for the winner only.
  - On the handshake: capture both operands and `grant`.
  - Divisor zero: load result register with all-ones and go to RESP.
  - Divisor non-zero: clear the `dd_done`/`ds_done` flags and go to LOAD.
- **LOAD:**
  - `div_dividend_tvalid = !dd_done` and `div_divisor_tvalid = !ds_done`, each driven from the captured registers.
  - Each flag sets on its own handshake; the two handshakes may complete in the same cycle or in different cycles.
  - Once both flags are set (including a set in the current cycle), go to WAIT.
- **WAIT:**
  - `div_output_tready = 1`.
  - On `div_output_tvalid`, capture `div_output_tdata` into the result register and go to RESP.
- **RESP:**
  - `resN_tvalid = 1` for N = grant only, with `resN_tdata` = result register.
  - On `resN_tready`, the priority pointer moves to the other requester and the FSM returns to IDLE.
- **Isolation:** the non-granted requester sees `tready = 0` and `tvalid = 0` throughout a transaction. The divider's tvalid and tready outputs are 0 outside LOAD and WAIT respectively.
- **Unexpected divider output:** `div_output_tvalid` outside WAIT is ignored (tready = 0).
- **Widths:** no arithmetic in the block; data is passed through unmodified at full width.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, pointer to req0, result register 0, `grant` 0.
- **Asynchronous reset:** asserting `rst` low mid-transaction abandons it immediately. The divider must share the same `rst` so no stale result survives.
- **Normal-path latency:**
  - Accept in cycle 0; LOAD in cycle 1.
  - With the divider ready, both input handshakes complete in cycle 1 and WAIT starts in cycle 2.
  - The result is presented in the cycle after `div_output_tvalid`.
- **Zero-divisor latency:** accept in cycle 0, `resN_tvalid` in cycle 1.
- **Throughput and back-to-back requests:** one transaction in flight at a time. Minimum spacing between consecutive accepts is RESP consumption plus one IDLE cycle.
- **Stability:** registered operands stay stable while divider tvalid is high and tready is low. The result stays stable while `resN_tvalid` is high and tready is low.

## Structure
- **Package `division_pkg`:** SIZE default (128), state enumeration (IDLE, LOAD, WAIT, RESP), DIV_ZERO_RESULT constant (all-ones).
- **Sub-module `rr_arbiter2`:** two-input round-robin arbiter with pointer-advance input; combinational grant plus registered pointer.
- **Top:** the top holds the FSM, operand/result registers and handshake flags.

## Test plan
- **Single request:** req0 sends 234095823 / 69814; a divider stub returns quotient after 10 cycles. Required: `res0_tdata` = 3353, `res0_tvalid` asserted exactly one cycle after the stub's output tvalid, `res1_tvalid` stays 0.
- **Simultaneous requests:** req0 and req1 valid in the same cycle after reset. Required: req0 served first, then req1 without req0 re-asserting. If both are valid again, req1's successor, req0, is served next (alternation).
- **Skewed handshakes:** stub holds `div_divisor_tready` low for 3 cycles after the dividend handshake. Required: dividend tvalid drops after its handshake, divisor tvalid persists with stable data, WAIT is entered only after both handshakes.
- **Divide by zero:** req1 sends 20610496227029426887129 / 0. Required: the divider sees no tvalid, `res1_tdata` is all-ones in cycle 1.
- **Result backpressure:** `res0_tready` held low 5 cycles. Required: data and tvalid stable, no new accept, `busy` = 1.
- **Reset mid-WAIT:** `rst` pulled low during WAIT. Required: all outputs 0 asynchronously, IDLE afterwards, and the next request is served correctly.
